// File: rtl/dispatcher3_pkg.sv
// Shared definitions for the three-channel dispatcher: channel-select codes,
// channel count, drop-counter width and a select decoder.
package dispatcher3_pkg;

  localparam int unsigned SEL_W      = 2;
  localparam int unsigned NUM_CH     = 3;
  localparam int unsigned DROP_CNT_W = 8;

  localparam logic [SEL_W-1:0] SEL_CH0     = 2'b00;
  localparam logic [SEL_W-1:0] SEL_CH1     = 2'b01;
  localparam logic [SEL_W-1:0] SEL_CH2     = 2'b10;
  localparam logic [SEL_W-1:0] SEL_INVALID = 2'b11;

  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

  // One-hot channel decode; the invalid code maps to no channel.
  function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    logic [NUM_CH-1:0] oh;
    oh = '0;
    case (sel)
      SEL_CH0: oh = 3'b001;
      SEL_CH1: oh = 3'b010;
      SEL_CH2: oh = 3'b100;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/dispatcher3_slot.sv
// One output channel register with valid/ready handshake.
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset
//   i_load           load i_data this cycle (input handshake to this channel)
//   i_data           word to load
//   i_ready          downstream consumer ready
//   o_valid, o_data  registered channel contents
//   o_ready_c        combinational: slot can take a word this cycle
module dispatcher3_slot #(
  parameter int unsigned BITS = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_load,
  input  logic [BITS-1:0] i_data,
  input  logic            i_ready,
  output logic            o_valid,
  output logic [BITS-1:0] o_data,
  output logic            o_ready_c
);

  logic            r_valid;
  logic [BITS-1:0] r_data;

  // Load wins over drain so a simultaneous drain+load keeps the slot full.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid   = r_valid;
  assign o_data    = r_data;
  assign o_ready_c = !r_valid || i_ready;

endmodule

// File: rtl/dispatcher3.sv
// Three-channel dispatcher: routes each accepted input word to one of three
// one-entry output registers by i_in_sel; code 11 discards the word and
// pulses o_drop on the next cycle.
// Optional feature (macro DISPATCHER3_DROP_CNT_EN): o_drop_count, a
// saturating 8-bit count of discarded words, updated together with o_drop.
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_in_valid, i_in_sel, i_in_data input word, destination, payload
//   o_in_ready_c                   combinational input ready
//   o_out_valid0..2, o_output0..2  channel contents
//   i_out_ready0..2                channel consumer ready
//   o_drop                         one-cycle discard pulse
//   o_drop_count                   discard counter (macro only)
module dispatcher3
  import dispatcher3_pkg::*;
#(
  parameter int unsigned BITS = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_in_valid,
  output logic                  o_in_ready_c,
  input  logic [SEL_W-1:0]      i_in_sel,
  input  logic [BITS-1:0]       i_in_data,
  output logic                  o_out_valid0,
  output logic                  o_out_valid1,
  output logic                  o_out_valid2,
  input  logic                  i_out_ready0,
  input  logic                  i_out_ready1,
  input  logic                  i_out_ready2,
  output logic [BITS-1:0]       o_output0,
  output logic [BITS-1:0]       o_output1,
  output logic [BITS-1:0]       o_output2,
  output logic                  o_drop
`ifdef DISPATCHER3_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0] o_drop_count
`endif
);

  logic [NUM_CH-1:0] w_slot_ready;
  logic [NUM_CH-1:0] w_load;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_drop_hs;
  logic              r_drop;

  // Ready depends only on the selected channel, never on i_in_valid.
  always_comb begin
    w_in_ready = 1'b1;
    case (i_in_sel)
      SEL_CH0: w_in_ready = w_slot_ready[0];
      SEL_CH1: w_in_ready = w_slot_ready[1];
      SEL_CH2: w_in_ready = w_slot_ready[2];
      default: w_in_ready = 1'b1;
    endcase
  end

  assign o_in_ready_c = w_in_ready;
  assign w_accept     = i_in_valid && w_in_ready;
  assign w_load       = w_accept ? sel_onehot(i_in_sel) : '0;
  assign w_drop_hs    = w_accept && (i_in_sel == SEL_INVALID);

  dispatcher3_slot #(.BITS(BITS)) u_slot0 (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_load    (w_load[0]),
    .i_data    (i_in_data),
    .i_ready   (i_out_ready0),
    .o_valid   (o_out_valid0),
    .o_data    (o_output0),
    .o_ready_c (w_slot_ready[0])
  );

  dispatcher3_slot #(.BITS(BITS)) u_slot1 (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_load    (w_load[1]),
    .i_data    (i_in_data),
    .i_ready   (i_out_ready1),
    .o_valid   (o_out_valid1),
    .o_data    (o_output1),
    .o_ready_c (w_slot_ready[1])
  );

  dispatcher3_slot #(.BITS(BITS)) u_slot2 (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_load    (w_load[2]),
    .i_data    (i_in_data),
    .i_ready   (i_out_ready2),
    .o_valid   (o_out_valid2),
    .o_data    (o_output2),
    .o_ready_c (w_slot_ready[2])
  );

  // Discard pulse, one cycle after the invalid-select handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_drop <= 1'b0;
    end else begin
      r_drop <= w_drop_hs;
    end
  end

  assign o_drop = r_drop;

`ifdef DISPATCHER3_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  // Saturating discard counter, same timing as o_drop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop_hs && (r_drop_cnt != DROP_CNT_MAX)) begin
      r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
    end
  end

  assign o_drop_count = r_drop_cnt;
`endif

endmodule

// File: tb/tb_dispatcher3.sv
// Self-checking bench for dispatcher3: directed scenarios plus randomized
// traffic, all checked against a transaction-level channel model.
module tb_dispatcher3;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sel;
  logic [15:0] in_data;
  logic        ov0, ov1, ov2;
  logic        or0, or1, or2;
  logic [15:0] od0, od1, od2;
  logic        drop;
`ifdef DISPATCHER3_DROP_CNT_EN
  logic [7:0]  drop_count;
`endif

  dispatcher3 #(.BITS(16)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_in_valid   (in_valid),
    .o_in_ready_c (in_ready),
    .i_in_sel     (in_sel),
    .i_in_data    (in_data),
    .o_out_valid0 (ov0),
    .o_out_valid1 (ov1),
    .o_out_valid2 (ov2),
    .i_out_ready0 (or0),
    .i_out_ready1 (or1),
    .i_out_ready2 (or2),
    .o_output0    (od0),
    .o_output1    (od1),
    .o_output2    (od2),
    .o_drop       (drop)
`ifdef DISPATCHER3_DROP_CNT_EN
    ,
    .o_drop_count (drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: what each channel holds, plus drop pulse and count.
  bit          m_full [3];
  logic [15:0] m_word [3];
  bit          m_drop;
  int          m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int n = 0; n < 3; n++) begin
      m_full[n] = 1'b0;
      m_word[n] = '0;
    end
    m_drop = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic check_outputs();
    check("valid0", 32'(ov0), 32'(m_full[0]));
    check("valid1", 32'(ov1), 32'(m_full[1]));
    check("valid2", 32'(ov2), 32'(m_full[2]));
    if (m_full[0]) check("data0", 32'(od0), 32'(m_word[0]));
    if (m_full[1]) check("data1", 32'(od1), 32'(m_word[1]));
    if (m_full[2]) check("data2", 32'(od2), 32'(m_word[2]));
    check("drop", 32'(drop), 32'(m_drop));
`ifdef DISPATCHER3_DROP_CNT_EN
    check("drop_count", 32'(drop_count), 32'(m_cnt));
`endif
  endtask

  // One cycle: drive at negedge, check ready, advance model, check outputs.
  task automatic step(input bit v, input logic [1:0] s, input logic [15:0] d,
                      input bit [2:0] r);
    bit exp_rdy;
    bit acc;
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    or0      = r[0];
    or1      = r[1];
    or2      = r[2];
    #1;
    if (s == 2'b11) exp_rdy = 1'b1;
    else            exp_rdy = !m_full[s] || r[s];
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    acc = v && exp_rdy;
    for (int n = 0; n < 3; n++) begin
      if (acc && (int'(s) == n)) begin
        m_full[n] = 1'b1;
        m_word[n] = d;
      end else if (m_full[n] && r[n]) begin
        m_full[n] = 1'b0;
      end
    end
    m_drop = acc && (s == 2'b11);
    if (m_drop && m_cnt < 255) m_cnt++;
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_valid0", 32'(ov0), 32'd0);
    check("rst_valid1", 32'(ov1), 32'd0);
    check("rst_valid2", 32'(ov2), 32'd0);
    check("rst_data0", 32'(od0), 32'd0);
    check("rst_data1", 32'(od1), 32'd0);
    check("rst_data2", 32'(od2), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef DISPATCHER3_DROP_CNT_EN
    check("rst_drop_count", 32'(drop_count), 32'd0);
`endif
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sel   = 2'b00;
    in_data  = '0;
    or0      = 1'b1;
    or1      = 1'b1;
    or2      = 1'b1;
    model_clear();
    @(negedge clk);
    do_reset();

    // Single word to channel 1.
    step(1'b1, 2'b01, 16'h1234, 3'b111);
    check("t1_valid1", 32'(ov1), 32'd1);
    check("t1_data1", 32'(od1), 32'h1234);
    check("t1_valid0", 32'(ov0), 32'd0);
    step(1'b0, 2'b00, 16'h0000, 3'b111);

    // Channel 0 backpressure.
    step(1'b1, 2'b00, 16'hAAAA, 3'b110);
    step(1'b1, 2'b00, 16'hBBBB, 3'b110);
    check("t2_held", 32'(od0), 32'hAAAA);
    step(1'b1, 2'b00, 16'hBBBB, 3'b111);
    check("t2_next", 32'(od0), 32'hBBBB);
    step(1'b0, 2'b00, 16'h0000, 3'b111);

    // Stalled channel 2 does not block channel 0.
    step(1'b1, 2'b10, 16'h0077, 3'b011);
    step(1'b1, 2'b00, 16'h0055, 3'b011);
    check("t3_data0", 32'(od0), 32'h0055);
    check("t3_data2", 32'(od2), 32'h0077);
    check("t3_valid2", 32'(ov2), 32'd1);
    step(1'b0, 2'b00, 16'h0000, 3'b111);

    // Back-to-back stream on channel 1.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 2'b01, 16'(16'h0100 + i), 3'b111);
      check("t4_order", 32'(od1), 32'(16'h0100 + i));
    end
    step(1'b0, 2'b00, 16'h0000, 3'b111);

    // Invalid selects: drops and counter saturation.
    for (int i = 0; i < 3; i++) step(1'b1, 2'b11, 16'(i), 3'b000);
`ifdef DISPATCHER3_DROP_CNT_EN
    check("t5_cnt3", 32'(drop_count), 32'd3);
`endif
    for (int i = 0; i < 297; i++) step(1'b1, 2'b11, 16'(i), 3'(i));
`ifdef DISPATCHER3_DROP_CNT_EN
    check("t5_cnt255", 32'(drop_count), 32'd255);
`endif
    step(1'b0, 2'b11, 16'h0000, 3'b111);

    // Reset with all channels full.
    step(1'b1, 2'b00, 16'h1111, 3'b000);
    step(1'b1, 2'b01, 16'h2222, 3'b000);
    step(1'b1, 2'b10, 16'h3333, 3'b000);
    check("t6_full", 32'({ov2, ov1, ov0}), 32'd7);
    do_reset();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 4) != 0, 2'($urandom), 16'($urandom), 3'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
